// File: rtl/sparse_expander.sv
// -----------------------------------------------------------------------------
// sparse_expander
//
// Rebuilds a dense activation stream from a keep mask plus a packed stream of
// surviving values. For every accepted G-bit mask the block emits exactly G
// W-bit elements, bit 0 first. A mask bit of 1 pulls the next packed value,
// and a mask bit of 0 emits a zero. All three interfaces use valid/ready.
//
// Optional build macro: SPARSE_EXPANDER_PIPE_EN
//   When defined, the next mask may be accepted in the same cycle as the last
//   element of the current group loads. This removes the one-cycle inter-group
//   bubble, so mask_ready then also depends on out_ready and val_valid.
//
// Parameters:
//   W - value width in bits
//   G - group size / mask width (power of two, >= 2)
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   mask_valid - mask word valid
//   mask_ready - block can accept a mask
//   mask       - keep mask, bit i = 1 means element i comes from val_data
//   val_valid  - packed value valid
//   val_ready  - block consumes the packed value this cycle
//   val_data   - packed nonzero value
//   out_valid  - dense output valid (registered)
//   out_ready  - downstream accepts the output
//   out_data   - dense output value (registered)
//   out_last   - marks element G-1 of a group (registered)
// -----------------------------------------------------------------------------
module sparse_expander #(
  parameter int W = 8,
  parameter int G = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mask_valid,
  output logic         mask_ready,
  input  logic [G-1:0] mask,
  input  logic         val_valid,
  output logic         val_ready,
  input  logic [W-1:0] val_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  localparam int            IW       = $clog2(G);
  localparam logic [IW-1:0] LAST_IDX = IW'(G - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [G-1:0]  mask_q_reg, mask_q_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          out_valid_reg, out_valid_next;
  logic [W-1:0]  out_data_reg, out_data_next;
  logic          out_last_reg, out_last_next;

  logic load_en;    // output register is empty or being drained
  logic keep_bit;   // mask bit of the element currently being expanded
  logic last_elem;  // current element is the last of the group
  logic elem_load;  // an element loads into the output register this cycle
  logic mask_xfer;

  assign load_en   = !out_valid_reg || out_ready;
  assign keep_bit  = mask_q_reg[idx_reg];
  assign last_elem = (idx_reg == LAST_IDX);

  // val_ready deliberately ignores val_valid so it can never form a loop with
  // a producer whose valid depends on ready.
  assign val_ready = (state_reg == EXPAND) && keep_bit && load_en;

  // A kept element needs its packed value to be present; a zero element
  // only needs room in the output register.
  assign elem_load = (state_reg == EXPAND) && load_en && (!keep_bit || val_valid);

`ifdef SPARSE_EXPANDER_PIPE_EN
  assign mask_ready = (state_reg == IDLE) || (last_elem && elem_load);
`else
  assign mask_ready = (state_reg == IDLE);
`endif

  assign mask_xfer = mask_valid && mask_ready;

  // Next-state and output-register logic
  always_comb begin
    state_next     = state_reg;
    mask_q_next    = mask_q_reg;
    idx_next       = idx_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;

    case (state_reg)
      IDLE: begin
        if (mask_xfer) begin
          mask_q_next = mask;
          idx_next    = '0;
          state_next  = EXPAND;
        end
      end

      EXPAND: begin
        if (elem_load) begin
          // G is a power of two, so the increment wraps to 0 after G-1.
          idx_next = idx_reg + 1'b1;
          if (last_elem) begin
            state_next = IDLE;
`ifdef SPARSE_EXPANDER_PIPE_EN
            if (mask_xfer) begin
              mask_q_next = mask;
              idx_next    = '0;
              state_next  = EXPAND;
            end
`endif
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (elem_load) begin
      out_valid_next = 1'b1;
      out_data_next  = keep_bit ? val_data : '0;
      out_last_next  = last_elem;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mask_q_reg    <= '0;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mask_q_reg    <= mask_q_next;
      idx_reg       <= idx_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_sparse_expander.sv
// -----------------------------------------------------------------------------
// tb_sparse_expander
//
// Scoreboard bench for sparse_expander (W=8, G=8). Each queued group pushes
// its packed values to a value queue and its dense expansion to an expected
// queue. A per-cycle step drives inputs on the falling edge and pops and
// compares every accepted output.
// -----------------------------------------------------------------------------
module tb_sparse_expander;

  localparam int W = 8;
  localparam int G = 8;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         mask_valid;
  logic         mask_ready;
  logic [G-1:0] mask;
  logic         val_valid;
  logic         val_ready;
  logic [W-1:0] val_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  sparse_expander #(.W(W), .G(G)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .mask       (mask),
    .val_valid  (val_valid),
    .val_ready  (val_ready),
    .val_data   (val_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [G-1:0] mask_q[$];
  logic [W-1:0] val_q[$];
  exp_t         exp_q[$];

  int chk_cnt      = 0;
  int pass_cnt     = 0;
  int cyc          = 0;
  int out_cnt      = 0;
  int val_xfer_cnt = 0;
  int first_cyc    = 0;
  int last_cyc     = 0;
  bit out_seen     = 0;
  bit vr_seen      = 0;
  int val_block    = 0;
  bit stall_trig_en = 0;
  int stall_trig   = 0;
  int stall_left   = 0;
  int stall_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Queue one group: packed values are first, first+stepv, ...
  task automatic add_group(input logic [G-1:0] m, input int first, input int stepv);
    int   k;
    exp_t e;
    k = 0;
    mask_q.push_back(m);
    for (int i = 0; i < G; i++) begin
      e.last = (i == G - 1);
      if (m[i]) begin
        e.data = W'(first + k * stepv);
        val_q.push_back(e.data);
        k++;
      end else begin
        e.data = '0;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    exp_t e;
    bit   stalling;
    @(negedge clk);
    cyc++;
    stalling  = (stall_left > 0);
    out_ready = !stalling;
    if (stalling) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data", out_data, 3);
      stall_cycles++;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_last", out_last, e.last);
      end
      $display("cyc %0d: out data=%0d last=%0d", cyc, out_data, out_last);
      out_cnt++;
      if (!out_seen) first_cyc = cyc;
      out_seen = 1;
      last_cyc = cyc;
      if (stall_trig_en && out_data == W'(stall_trig)) begin
        stall_left    = 3;
        stall_trig_en = 0;
      end
    end
    mask_valid = (mask_q.size() > 0);
    mask       = mask_valid ? mask_q[0] : '0;
    val_valid  = (val_q.size() > 0) && (val_block == 0);
    val_data   = val_valid ? val_q[0] : '0;
    if (val_block > 0) val_block--;
    #1;
    if (val_ready) vr_seen = 1;
    if (stalling) begin
      check("stall_val_ready", val_ready, 0);
      stall_left--;
    end
    if (mask_valid && mask_ready) mask_q.pop_front();
    if (val_valid && val_ready) begin
      void'(val_q.pop_front());
      val_xfer_cnt++;
    end
  endtask

  task automatic start_group_stats();
    out_seen     = 0;
    vr_seen      = 0;
    val_xfer_cnt = 0;
    out_cnt      = 0;
  endtask

  // Run until everything queued has been emitted, then idle a few cycles to
  // catch any spurious extra outputs.
  task automatic drain(input string tag);
    int budget;
    budget = 300;
    while ((exp_q.size() > 0 || mask_q.size() > 0) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check({tag, "_timeout"}, 0, 1);
    repeat (3) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_mask_ready"}, mask_ready, 1);
    check({tag, "_val_ready"}, val_ready, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
  endtask

  initial begin
    int budget;
    rst_n      = 1'b0;
    mask_valid = 1'b0;
    mask       = '0;
    val_valid  = 1'b0;
    val_data   = '0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Sparse group
    start_group_stats();
    add_group(8'hA5, 11, 11);
    drain("sparse");
    check("sparse_val_xfers", val_xfer_cnt, 4);
    check("sparse_span", last_cyc - first_cyc, 7);

    // All-zero group
    start_group_stats();
    add_group(8'h00, 0, 0);
    drain("zeros");
    check("zeros_val_ready_seen", vr_seen, 0);
    check("zeros_count", out_cnt, 8);

    // All-ones group
    start_group_stats();
    add_group(8'hFF, 1, 1);
    drain("ones");
    check("ones_val_xfers", val_xfer_cnt, 8);

    // Backpressure after element 2
    start_group_stats();
    stall_cycles  = 0;
    stall_trig    = 2;
    stall_trig_en = 1;
    add_group(8'hFF, 1, 1);
    drain("stall");
    check("stall_cycles", stall_cycles, 3);
    check("stall_val_xfers", val_xfer_cnt, 8);

    // Value starvation
    start_group_stats();
    val_block = 5;
    add_group(8'h0C, 5, 1);
    drain("starve");
    check("starve_span", last_cyc - first_cyc, 9);

    // Reset mid-group
    start_group_stats();
    add_group(8'hFF, 1, 1);
    budget = 50;
    while (out_cnt < 3 && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) check("midrst_timeout", 0, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    mask_q.delete();
    val_q.delete();
    exp_q.delete();
    mask_valid = 1'b0;
    val_valid  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_group_stats();
    add_group(8'h01, 9, 1);
    drain("postrst");
    check("postrst_count", out_cnt, 8);

    // Back-to-back groups
    start_group_stats();
    add_group(8'hFF, 1, 1);
    add_group(8'hFF, 9, 1);
    drain("b2b");
`ifdef SPARSE_EXPANDER_PIPE_EN
    check("b2b_span", last_cyc - first_cyc, 15);
`else
    check("b2b_span", last_cyc - first_cyc, 16);
`endif
    check("b2b_count", out_cnt, 16);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
